// File: rtl/row_cache_ctrl.sv
// Per-bank row-cache controller: fully-associative tag lookup on ACT, victim
// writeback and fill through the backing-memory port, halt while a miss is in flight.
module row_cache_ctrl #(
    parameter int unsigned ROWWIDTH  = 17,
    parameter int unsigned SLOTWIDTH = 5
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 act,
    input  logic [ROWWIDTH-1:0]  row,
    input  logic                 wr,
    input  logic                 pre,
    output logic [SLOTWIDTH-1:0] slot,
    output logic                 slot_valid,
    output logic                 halt,
    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic                 mem_req_we,
    output logic [ROWWIDTH-1:0]  mem_req_row,
    output logic [SLOTWIDTH-1:0] mem_req_slot,
    input  logic                 mem_done
);

    localparam int unsigned SLOTS = 1 << SLOTWIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WB_REQ,
        S_WB_WAIT,
        S_FILL_REQ,
        S_FILL_WAIT
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [SLOTS-1:0]      r_valid;
    logic [SLOTS-1:0]      r_dirty;
    logic [ROWWIDTH-1:0]   r_tag [SLOTS];
    logic [SLOTWIDTH-1:0]  r_rr_ptr;
    logic [SLOTWIDTH-1:0]  r_victim;
    logic [ROWWIDTH-1:0]   r_new_row;

    logic [SLOTWIDTH-1:0]  r_slot;
    logic                  r_slot_valid;
    logic                  r_halt;
    logic                  r_mem_req_valid;
    logic                  r_mem_req_we;
    logic [ROWWIDTH-1:0]   r_mem_req_row;
    logic [SLOTWIDTH-1:0]  r_mem_req_slot;

    logic                  w_hit;
    logic [SLOTWIDTH-1:0]  w_hit_idx;
    logic                  w_has_free;
    logic [SLOTWIDTH-1:0]  w_free_idx;
    logic [SLOTWIDTH-1:0]  w_victim;
    logic                  w_wr_mark;
    logic                  w_victim_dirty;

    logic                  w_miss;
    logic                  w_hit_act;
    logic                  w_pre_close;
    logic                  w_wb_done;
    logic                  w_fill_done;
    logic                  w_req_valid_nxt;
    logic                  w_req_we_nxt;
    logic [ROWWIDTH-1:0]   w_req_row_nxt;
    logic [SLOTWIDTH-1:0]  w_req_slot_nxt;

    // Tag match and lowest-index free entry
    always_comb begin
        w_hit      = 1'b0;
        w_hit_idx  = '0;
        w_has_free = 1'b0;
        w_free_idx = '0;
        for (int i = 0; i < int'(SLOTS); i++) begin
            if (r_valid[i] && (r_tag[i] == row)) begin
                w_hit     = 1'b1;
                w_hit_idx = SLOTWIDTH'(i);
            end
            if (!w_has_free && !r_valid[i]) begin
                w_has_free = 1'b1;
                w_free_idx = SLOTWIDTH'(i);
            end
        end
    end

    // A same-cycle write lands before the victim's dirty bit is examined
    assign w_victim       = w_has_free ? w_free_idx : r_rr_ptr;
    assign w_wr_mark      = (r_state == S_IDLE) && wr && r_slot_valid;
    assign w_victim_dirty = r_valid[w_victim] &&
                            (r_dirty[w_victim] || (w_wr_mark && (r_slot == w_victim)));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_miss      = 1'b0;
        w_hit_act   = 1'b0;
        w_pre_close = 1'b0;
        w_wb_done   = 1'b0;
        w_fill_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (act) begin
                    if (w_hit) begin
                        w_hit_act = 1'b1;
                    end else begin
                        w_miss      = 1'b1;
                        w_state_nxt = w_victim_dirty ? S_WB_REQ : S_FILL_REQ;
                    end
                end else if (pre) begin
                    w_pre_close = 1'b1;
                end
            end
            S_WB_REQ: begin
                if (mem_req_ready) w_state_nxt = S_WB_WAIT;
            end
            S_WB_WAIT: begin
                if (mem_done) begin
                    w_wb_done   = 1'b1;
                    w_state_nxt = S_FILL_REQ;
                end
            end
            S_FILL_REQ: begin
                if (mem_req_ready) w_state_nxt = S_FILL_WAIT;
            end
            S_FILL_WAIT: begin
                if (mem_done) begin
                    w_fill_done = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        w_req_valid_nxt = (w_state_nxt == S_WB_REQ) || (w_state_nxt == S_FILL_REQ);
        w_req_we_nxt    = (w_state_nxt == S_WB_REQ);
        w_req_row_nxt   = r_mem_req_row;
        w_req_slot_nxt  = r_mem_req_slot;
        if (w_state_nxt == S_WB_REQ) begin
            w_req_row_nxt  = w_miss ? r_tag[w_victim] : r_mem_req_row;
            w_req_slot_nxt = w_miss ? w_victim : r_victim;
        end else if (w_state_nxt == S_FILL_REQ) begin
            w_req_row_nxt  = w_miss ? row : r_new_row;
            w_req_slot_nxt = w_miss ? w_victim : r_victim;
        end
    end

    // Tag store, miss context and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid         <= '0;
            r_dirty         <= '0;
            r_rr_ptr        <= '0;
            r_victim        <= '0;
            r_new_row       <= '0;
            r_slot          <= '0;
            r_slot_valid    <= 1'b0;
            r_halt          <= 1'b0;
            r_mem_req_valid <= 1'b0;
            r_mem_req_we    <= 1'b0;
            r_mem_req_row   <= '0;
            r_mem_req_slot  <= '0;
            for (int i = 0; i < int'(SLOTS); i++) r_tag[i] <= '0;
        end else begin
            r_halt          <= (w_state_nxt != S_IDLE);
            r_mem_req_valid <= w_req_valid_nxt;
            r_mem_req_we    <= w_req_we_nxt;
            r_mem_req_row   <= w_req_row_nxt;
            r_mem_req_slot  <= w_req_slot_nxt;

            if (w_wr_mark) r_dirty[r_slot] <= 1'b1;
            if (w_pre_close) r_slot_valid <= 1'b0;
            if (w_hit_act) begin
                r_slot       <= w_hit_idx;
                r_slot_valid <= 1'b1;
            end
            if (w_miss) begin
                r_victim     <= w_victim;
                r_new_row    <= row;
                r_slot_valid <= 1'b0;
                if (!w_has_free) r_rr_ptr <= r_rr_ptr + SLOTWIDTH'(1);
            end
            if (w_wb_done) r_dirty[r_victim] <= 1'b0;
            if (w_fill_done) begin
                r_valid[r_victim] <= 1'b1;
                r_dirty[r_victim] <= 1'b0;
                r_tag[r_victim]   <= r_new_row;
                r_slot            <= r_victim;
                r_slot_valid      <= 1'b1;
            end
        end
    end

    assign slot          = r_slot;
    assign slot_valid    = r_slot_valid;
    assign halt          = r_halt;
    assign mem_req_valid = r_mem_req_valid;
    assign mem_req_we    = r_mem_req_we;
    assign mem_req_row   = r_mem_req_row;
    assign mem_req_slot  = r_mem_req_slot;

endmodule
